// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding
// and the index-width helper used for ptr/gnt_id/winner.
package bus_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master: arbiter side (drives grant info); slave: requester side (drives rq).
interface bus_arbiter_rr_if #(
  parameter int N_REQ = 4
) ();
  import bus_arb_pkg::*;

  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0] rq;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             busy;

  modport master (
    input  rq,
    output gnt,
    output gnt_id,
    output busy
  );

  modport slave (
    output rq,
    input  gnt,
    input  gnt_id,
    input  busy
  );

endinterface

// File: rtl/bus_arbiter_rr_select.sv
// rr_select: combinational rotate-priority picker. Searches rq starting at
// ptr+1 and wrapping modulo N_REQ (works for non-power-of-2 N_REQ), so the
// requester at ptr itself is checked last.
module rr_select
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] rq,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  // First set request in rotated order after ptr.
  always_comb begin
    int idx;
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && rq[IDX_W'(idx)]) begin
        any    = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter with a registered one-hot grant held
// while the owner keeps its request, and one idle turnaround cycle between
// owners. Optional forced release after MAX_HOLD grant cycles is enabled by
// defining the macro BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_arbiter_rr_if.master  bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_e       state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_nx;
  logic [N_REQ-1:0] gnt_q, gnt_nx;
  logic             any;
  logic [IDX_W-1:0] win;
  logic             rel;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .rq     (bus.rq),
    .ptr    (ptr),
    .any    (any),
    .winner (win)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic              others;

  // Another requester is waiting; only then may the owner be preempted.
  assign others = |(bus.rq & ~gnt_q);
  assign rel    = !bus.rq[gnt_id_q] || ((hold_cnt == HOLD_LAST) && others);

  // Grant-duration counter, cleared on every entry to GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_nx;
  end
`else
  assign rel = !bus.rq[gnt_id_q];
`endif

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IDX_W'(N_REQ - 1);
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gnt_q    <= gnt_nx;
      gnt_id_q <= gnt_id_nx;
    end
  end

  // Next-state: arbitrate in IDLE/TURN, hold or release in GRANT.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    gnt_nx    = gnt_q;
    gnt_id_nx = gnt_id_q;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_cnt_nx = hold_cnt;
`endif
    case (state)
      IDLE, TURN: begin
        if (any) begin
          state_nx  = GRANT;
          gnt_nx    = ONE << win;
          gnt_id_nx = win;
          ptr_nx    = win;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_cnt_nx = '0;
`endif
        end else begin
          state_nx = IDLE;
          gnt_nx   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          // Release (voluntary or forced); new requests are resolved in TURN.
          state_nx = TURN;
          gnt_nx   = '0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (N_REQ=4, MAX_HOLD=4). Covers reset,
// rotation, wrap/skip, reset mid-grant and the hold/timeout behaviour for
// either setting of BUS_ARB_TIMEOUT_EN, plus continuous grant invariants.
module tb_bus_arbiter_rr;
  import bus_arb_pkg::*;

  localparam int N  = 4;
  localparam int MH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.N_REQ(N)) bus ();

  bus_arbiter_rr #(
    .N_REQ    (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Continuous invariants sampled mid-cycle.
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert ($onehot0(bus.gnt)) passed++;
      else $error("FAIL onehot0: gnt %b", bus.gnt);
      total++;
      assert (bus.busy === (dut.state != IDLE)) passed++;
      else $error("FAIL busy_state: busy %b state %0d", bus.busy, dut.state);
      total++;
      assert (!((prev_gnt != '0) && (bus.gnt != '0) && (bus.gnt != prev_gnt))) passed++;
      else $error("FAIL owner_gap: prev %b now %b", prev_gnt, bus.gnt);
      prev_gnt = bus.gnt;
    end else begin
      prev_gnt = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bus.rq = 4'b1111;
    rst_n  = 1'b0;

    // T1: reset holds outputs low, then 1-cycle latency to first grant
    #3;
    chk("t1_rst_gnt",  32'(bus.gnt), 32'h0);
    chk("t1_rst_busy", 32'(bus.busy), 32'h0);
    chk("t1_rst_id",   32'(bus.gnt_id), 32'h0);
    tick();
    tick();
    chk("t1_rst_gnt2", 32'(bus.gnt), 32'h0);
    bus.rq = 4'b0001;
    rst_n  = 1'b1;
    tick();
    chk("t1_gnt",  32'(bus.gnt), 32'h1);
    chk("t1_id",   32'(bus.gnt_id), 32'h0);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    bus.rq = 4'b0000;
    tick();
    chk("t1_turn_gnt",  32'(bus.gnt), 32'h0);
    chk("t1_turn_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'h0);

    // T2: rotation 0,1,2,3,0 with a gap cycle between owners
    rst_pulse();
    bus.rq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      tick();
      chk("t2_grant", 32'(bus.gnt), 32'(oh(e)));
      chk("t2_id",    32'(bus.gnt_id), 32'(e));
      tick();
      chk("t2_hold",  32'(bus.gnt), 32'(oh(e)));
      bus.rq = 4'b1111 & ~oh(e);
      tick();
      chk("t2_gap",      32'(bus.gnt), 32'h0);
      chk("t2_gap_busy", 32'(bus.busy), 32'h1);
      bus.rq = 4'b1111;
    end

    // T3: wrap and skip (currently in TURN with ptr=0)
    bus.rq = 4'b1000;
    tick();
    chk("t3_gnt3", 32'(bus.gnt), 32'h8);
    bus.rq = 4'b0110;
    tick();
    chk("t3_gap3", 32'(bus.gnt), 32'h0);
    tick();
    chk("t3_wrap", 32'(bus.gnt), 32'h2);
    chk("t3_wrap_id", 32'(bus.gnt_id), 32'h1);
    bus.rq = 4'b0100;
    tick();
    chk("t3_gap1", 32'(bus.gnt), 32'h0);
    tick();
    chk("t3_gnt2", 32'(bus.gnt), 32'h4);
    bus.rq = 4'b1001;
    tick();
    chk("t3_gap2", 32'(bus.gnt), 32'h0);
    tick();
    chk("t3_skip", 32'(bus.gnt), 32'h8);
    chk("t3_skip_id", 32'(bus.gnt_id), 32'h3);
    tick();
    chk("t3_ignore1", 32'(bus.gnt), 32'h8);
    tick();
    chk("t3_ignore2", 32'(bus.gnt), 32'h8);

    // T5: reset mid-grant clears at once, restart from requester 0
    bus.rq = 4'b0100;
    tick();
    chk("t5_gap", 32'(bus.gnt), 32'h0);
    tick();
    chk("t5_gnt2", 32'(bus.gnt), 32'h4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt",  32'(bus.gnt), 32'h0);
    chk("t5_async_busy", 32'(bus.busy), 32'h0);
    bus.rq = 4'b1111;
    #2;
    rst_n = 1'b1;
    tick();
    chk("t5_restart", 32'(bus.gnt), 32'h1);
    chk("t5_restart_id", 32'(bus.gnt_id), 32'h0);

    // T4: hold limit behaviour
    rst_pulse();
    bus.rq = 4'b0011;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (((c - 1) % 5) == 4) chk("t4_to_gap", 32'(bus.gnt), 32'h0);
      else if ((((c - 1) / 5) % 2) == 0) chk("t4_to_own0", 32'(bus.gnt), 32'h1);
      else chk("t4_to_own1", 32'(bus.gnt), 32'h2);
    end
    rst_pulse();
    bus.rq = 4'b0001;
    tick();
    chk("t4_solo_gnt", 32'(bus.gnt), 32'h1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t4_solo_hold", 32'(bus.gnt), 32'h1);
    end
`else
    tick();
    chk("t4_gnt", 32'(bus.gnt), 32'h1);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t4_no_timeout", 32'(bus.gnt), 32'h1);
    end
`endif

    bus.rq = 4'b0000;
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
